// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: instruction fields,
// FSM states, ALU operation codes and datapath mux selects.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RT   = 6'd0;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_BNE  = 6'd5;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;

  localparam logic [5:0] FN_NOP = 6'd0;
  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_LT  = 3'd4;

  localparam logic [1:0] SRCB_REG    = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADDR  = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXEC     = 4'd7,
    S_RWB      = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12
  } state_t;

endpackage

// File: rtl/mc_alu_decoder.sv
// R-type func field to ALU operation decode; valid is low for any func the
// controller does not execute (including NOP, which the top handles itself).
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] func,
  output logic [2:0] alu_op,
  output logic       valid
);

  always_comb begin
    alu_op = ALU_ADD;
    valid  = 1'b1;
    case (func)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_LT;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Sequenced control FSM for the multicycle MIPS datapath, with retired and
// illegal instruction counters. Outputs decode combinationally from the state.
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_SEL_W = 3,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           opcode,
  input  logic [5:0]           func,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 iord,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [ALU_SEL_W-1:0] alu_sel,
  output logic                 illegal,
  output logic [CNT_W-1:0]     retired_cnt,
  output logic [CNT_W-1:0]     illegal_cnt
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;
  logic [2:0]       alu_op;
  logic [2:0]       r_alu_op;
  logic             r_valid;
  logic             retire;

  mc_alu_decoder u_alu_decoder (
    .func   (func),
    .alu_op (r_alu_op),
    .valid  (r_valid)
  );

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_ALU;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = ALU_ADD;
    illegal    = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        state_d   = S_FETCH;
        case (opcode)
          OP_LW, OP_SW:   state_d = S_MEMADDR;
          OP_ADDI:        state_d = S_ADDIEX;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          OP_RT: begin
            if (r_valid)            state_d = S_EXEC;
            else if (func != FN_NOP) illegal = 1'b1;
          end
          default:        illegal = 1'b1;
        endcase
      end
      S_MEMADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = r_alu_op;
        state_d   = S_RWB;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PC_SRC_ALUOUT;
        pc_write  = (opcode == OP_BEQ) ? zero : ~zero;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src   = PC_SRC_JUMP;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign alu_sel = ALU_SEL_W'(alu_op);

  // Stalls in FETCH are not transitions, and the IDLE exit is not a retirement.
  assign retire = (state_d == S_FETCH) && (state_q != S_FETCH) &&
                  (state_q != S_IDLE) && !illegal;

  always_comb begin
    retired_cnt_d = retired_cnt_q;
    illegal_cnt_d = illegal_cnt_q;
    if (retire)  retired_cnt_d = retired_cnt_q + CNT_W'(1);
    if (illegal) illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      retired_cnt_q <= '0;
      illegal_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      retired_cnt_q <= retired_cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign retired_cnt = retired_cnt_q;
  assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction vectors expand
// into expected per-cycle control words that are queued and compared each cycle.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode, func;
  logic        zero, mem_ready;
  logic        pc_write, iord, mem_read, mem_write, ir_write;
  logic        reg_write, reg_dst, mem_to_reg, alu_src_a, illegal;
  logic [1:0]  pc_src, alu_src_b;
  logic [2:0]  alu_sel;
  logic [31:0] retired_cnt, illegal_cnt;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_sel;
    logic       illegal;
  } ctl_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         fetch_stall;
    int         mem_stall;
    int         exp_retire;
    int         exp_illegal;
  } vec_t;

  typedef struct {
    logic ready;
    ctl_t exp;
  } cyc_t;

  cyc_t sb[$];
  ctl_t act;
  int   vectors = 0;
  int   errors  = 0;
  int   model_retired = 0;
  int   model_illegal = 0;

  multicycle_controller #(.ALU_SEL_W(3), .CNT_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .func        (func),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .iord        (iord),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .reg_write   (reg_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_sel     (alu_sel),
    .illegal     (illegal),
    .retired_cnt (retired_cnt),
    .illegal_cnt (illegal_cnt)
  );

  always #5 clk = ~clk;

  assign act = {pc_write, pc_src, iord, mem_read, mem_write, ir_write, reg_write,
                reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_sel, illegal};

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Instruction class: 0 LW, 1 SW, 2 R-type, 3 ADDI, 4 branch, 5 J, 6 NOP, 7 illegal
  function automatic int kind_of(logic [5:0] op, logic [5:0] fn);
    case (op)
      6'd35: return 0;
      6'd43: return 1;
      6'd8:  return 3;
      6'd4, 6'd5: return 4;
      6'd2:  return 5;
      6'd0: begin
        if (fn == 6'd0) return 6;
        if (fn == 6'd32 || fn == 6'd34 || fn == 6'd36 || fn == 6'd37 || fn == 6'd42)
          return 2;
        return 7;
      end
      default: return 7;
    endcase
  endfunction

  function automatic logic [2:0] r_sel(logic [5:0] fn);
    case (fn)
      6'd34:   return 3'd1;
      6'd36:   return 3'd2;
      6'd37:   return 3'd3;
      6'd42:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic void push(logic ready, ctl_t c);
    cyc_t e;
    e.ready = ready;
    e.exp   = c;
    sb.push_back(e);
  endfunction

  function automatic ctl_t fetch_ctl(logic done);
    ctl_t c = '0;
    c.mem_read  = 1'b1;
    c.alu_src_b = 2'd1;
    c.ir_write  = done;
    c.pc_write  = done;
    return c;
  endfunction

  function automatic void build(vec_t v);
    ctl_t c;
    int   k = kind_of(v.op, v.fn);
    for (int i = 0; i < v.fetch_stall; i++) push(1'b0, fetch_ctl(1'b0));
    push(1'b1, fetch_ctl(1'b1));
    c = '0; c.alu_src_b = 2'd3; c.illegal = (k == 7);
    push(1'b1, c);
    case (k)
      0, 1: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'd2;
        push(1'b1, c);
        c = '0; c.iord = 1'b1;
        if (k == 0) c.mem_read = 1'b1; else c.mem_write = 1'b1;
        for (int i = 0; i < v.mem_stall; i++) push(1'b0, c);
        push(1'b1, c);
        if (k == 0) begin
          c = '0; c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
          push(1'b1, c);
        end
      end
      2: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_sel = r_sel(v.fn);
        push(1'b1, c);
        c = '0; c.reg_write = 1'b1; c.reg_dst = 1'b1;
        push(1'b1, c);
      end
      3: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'd2;
        push(1'b1, c);
        c = '0; c.reg_write = 1'b1;
        push(1'b1, c);
      end
      4: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_sel = 3'd1; c.pc_src = 2'd1;
        c.pc_write = (v.op == 6'd4) ? v.z : ~v.z;
        push(1'b1, c);
      end
      5: begin
        c = '0; c.pc_src = 2'd2; c.pc_write = 1'b1;
        push(1'b1, c);
      end
      default: ;
    endcase
  endfunction

  task automatic check_output(string name, logic [31:0] actual, logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Starts in FETCH; drives one instruction and compares every cycle until the next FETCH.
  task automatic apply_stimulus(vec_t v, int idx);
    cyc_t e;
    int   cyc = 0;
    build(v);
    opcode = v.op;
    func   = v.fn;
    zero   = v.z;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mem_ready = e.ready;
      @(negedge clk);
      check_output($sformatf("instr%0d cyc%0d ctl", idx, cyc), 32'(act), 32'(e.exp));
      @(posedge clk);
      #1;
      cyc++;
    end
    model_retired += v.exp_retire;
    model_illegal += v.exp_illegal;
    check_output($sformatf("instr%0d back_in_fetch", idx),
                 {29'd0, mem_read, iord, mem_write}, 32'b100);
    check_output($sformatf("instr%0d retired_cnt", idx), retired_cnt, 32'(model_retired));
    check_output($sformatf("instr%0d illegal_cnt", idx), illegal_cnt, 32'(model_illegal));
  endtask

  vec_t tbl[16];

  initial begin
    //          op     fn     z     fstall mstall ret ill
    tbl[0]  = '{6'd35, 6'd0,  1'b0, 0, 0, 1, 0};
    tbl[1]  = '{6'd43, 6'd0,  1'b0, 0, 3, 1, 0};
    tbl[2]  = '{6'd4,  6'd0,  1'b1, 0, 0, 1, 0};
    tbl[3]  = '{6'd5,  6'd0,  1'b1, 0, 0, 1, 0};
    tbl[4]  = '{6'd0,  6'd42, 1'b0, 0, 0, 1, 0};
    tbl[5]  = '{6'd8,  6'd0,  1'b0, 0, 0, 1, 0};
    tbl[6]  = '{6'd63, 6'd0,  1'b0, 0, 0, 0, 1};
    tbl[7]  = '{6'd0,  6'd7,  1'b0, 0, 0, 0, 1};
    tbl[8]  = '{6'd0,  6'd0,  1'b1, 0, 0, 1, 0};
    tbl[9]  = '{6'd2,  6'd0,  1'b0, 1, 0, 1, 0};
    tbl[10] = '{6'd0,  6'd32, 1'b1, 2, 0, 1, 0};
    tbl[11] = '{6'd0,  6'd34, 1'b0, 0, 0, 1, 0};
    tbl[12] = '{6'd0,  6'd36, 1'b0, 0, 0, 1, 0};
    tbl[13] = '{6'd0,  6'd37, 1'b1, 0, 0, 1, 0};
    tbl[14] = '{6'd4,  6'd0,  1'b0, 0, 0, 1, 0};
    tbl[15] = '{6'd35, 6'd0,  1'b1, 1, 2, 1, 0};

    rst_n = 1'b0; opcode = '0; func = '0; zero = 1'b0; mem_ready = 1'b0;
    #12;
    check_output("reset ctl", 32'(act), 32'd0);
    check_output("reset retired_cnt", retired_cnt, 32'd0);
    check_output("reset illegal_cnt", illegal_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) apply_stimulus(tbl[i], i);
    // BNE with zero clear must take the branch
    apply_stimulus('{6'd5, 6'd0, 1'b0, 0, 0, 1, 0}, 16);

    // Reset dropped while a load waits in MEMREAD
    opcode = 6'd35; func = 6'd0; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mem_ready = 1'b0;
    #1;
    check_output("pre-reset in memread", {30'd0, mem_read, iord}, 32'b11);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async reset ctl", 32'(act), 32'd0);
    check_output("async reset retired_cnt", retired_cnt, 32'd0);
    check_output("async reset illegal_cnt", illegal_cnt, 32'd0);
    model_retired = 0;
    model_illegal = 0;
    @(posedge clk);
    @(negedge clk);
    check_output("held reset ctl", 32'(act), 32'd0);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    check_output("fetch after reset", 32'(act), 32'(fetch_ctl(1'b1)));
    apply_stimulus('{6'd8, 6'd0, 1'b0, 0, 0, 1, 0}, 17);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
